// File: rtl/cpu_mem_pkg.sv
// Shared types and default widths for the SRAM port arbiter.
//   arb_state_e : access sequencer states
//   owner_e     : which requester owns the access in flight
//   max2()      : helper for sizing the shared cycle timer
package cpu_mem_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_SRAM_ADDR_W = 18;
    localparam int DEF_DATA_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_RD       = 3'd1,
        ST_RD_DONE  = 3'd2,
        ST_WR_SETUP = 3'd3,
        ST_WR_PULSE = 3'd4,
        ST_WR_HOLD  = 3'd5
    } arb_state_e;

    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } owner_e;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// Loadable down-counter with terminal-count flag. Times both the OE-low
// window of a read and the WE-low window of a write.
//   clk, rst  : clock, async active-low reset
//   load      : load load_val (has priority over dec)
//   load_val  : cycles remaining minus one
//   dec       : count down by one, saturating at zero
//   tc        : counter is at zero (last cycle of the timed window)
module mem_arb_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port SRAM between instruction fetch (read-only)
// and the MEM stage (load/store), and sequences the SRAM strobes.
//   if_*   : IF requester (level req held until if_done pulse)
//   mem_*  : MEM requester (level req, mem_we selects write)
//   *_stall: combinational req & ~done, fed to pipeline hazard logic
//   sram_* : registered pad-side address, data and active-low strobes
//
// state       | meaning
// ST_IDLE     | strobes off, sample requests, grant one
// ST_RD       | CE/OE low for RD_CYC cycles, capture data on the last
// ST_RD_DONE  | strobes off, owner's done pulse
// ST_WR_SETUP | CE low, bus driven, WE still high
// ST_WR_PULSE | WE low for WR_PULSE_CYC cycles
// ST_WR_HOLD  | WE high, bus still driven, mem_done pulse
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int SRAM_ADDR_W  = DEF_SRAM_ADDR_W,
    parameter int DATA_W       = DEF_DATA_W,
    parameter int RD_CYC       = 1,
    parameter int WR_PULSE_CYC = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   if_req,
    input  logic [ADDR_W-1:0]      if_addr,
    output logic                   if_done,
    output logic [DATA_W-1:0]      if_rdata,
    output logic                   if_stall,
    input  logic                   mem_req,
    input  logic                   mem_we,
    input  logic [ADDR_W-1:0]      mem_addr,
    input  logic [DATA_W-1:0]      mem_wdata,
    output logic                   mem_done,
    output logic [DATA_W-1:0]      mem_rdata,
    output logic                   mem_stall,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0]      sram_dout,
    input  logic [DATA_W-1:0]      sram_din,
    output logic                   sram_data_oe,
    output logic                   sram_ce_n,
    output logic                   sram_oe_n,
    output logic                   sram_we_n
);

    localparam int               MAX_CYC = max2(RD_CYC, WR_PULSE_CYC);
    localparam int               CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYC - 1);
    localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_PULSE_CYC - 1);

    arb_state_e             state_q, state_d;
    owner_e                 owner_q, owner_d;
    logic                   last_mem_q, last_mem_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic [DATA_W-1:0]      sram_dout_q, sram_dout_d;
    logic [DATA_W-1:0]      if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]      mem_rdata_q, mem_rdata_d;
    logic                   ce_n_q, ce_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   we_n_q, we_n_d;
    logic                   data_oe_q, data_oe_d;
    logic                   if_done_q, if_done_d;
    logic                   mem_done_q, mem_done_d;

    logic                   grant_if, grant_mem;
    logic                   tmr_load, tmr_dec, tmr_tc;
    logic [CNT_W-1:0]       tmr_load_val;

    // MEM has priority unless it took the previous grant, so a held MEM
    // request cannot starve fetch.
    assign grant_mem = mem_req & (~if_req | ~last_mem_q);
    assign grant_if  = if_req & ~grant_mem;

    mem_arb_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_mem_d   = last_mem_q;
        sram_addr_d  = sram_addr_q;
        sram_dout_d  = sram_dout_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        tmr_load     = 1'b0;
        tmr_load_val = RD_LOAD;
        tmr_dec      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_mem) begin
                    owner_d     = OWN_MEM;
                    last_mem_d  = 1'b1;
                    sram_addr_d = SRAM_ADDR_W'(mem_addr);
                    if (mem_we) begin
                        sram_dout_d = mem_wdata;
                        state_d     = ST_WR_SETUP;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = ST_RD;
                    end
                end else if (grant_if) begin
                    owner_d     = OWN_IF;
                    last_mem_d  = 1'b0;
                    sram_addr_d = SRAM_ADDR_W'(if_addr);
                    tmr_load    = 1'b1;
                    state_d     = ST_RD;
                end
            end
            ST_RD: begin
                if (tmr_tc) begin
                    if (owner_q == OWN_MEM) begin
                        mem_rdata_d = sram_din;
                    end else begin
                        if_rdata_d = sram_din;
                    end
                    state_d = ST_RD_DONE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_RD_DONE: begin
                state_d = ST_IDLE;
            end
            ST_WR_SETUP: begin
                tmr_load     = 1'b1;
                tmr_load_val = WR_LOAD;
                state_d      = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (tmr_tc) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes and done pulses are decoded from the next state and
        // registered, so the pads switch cleanly on the clock edge.
        ce_n_d     = (state_d == ST_IDLE) || (state_d == ST_RD_DONE);
        oe_n_d     = (state_d != ST_RD);
        we_n_d     = (state_d != ST_WR_PULSE);
        data_oe_d  = (state_d == ST_WR_SETUP) || (state_d == ST_WR_PULSE) ||
                     (state_d == ST_WR_HOLD);
        if_done_d  = (state_d == ST_RD_DONE) && (owner_d == OWN_IF);
        mem_done_d = ((state_d == ST_RD_DONE) && (owner_d == OWN_MEM)) ||
                     (state_d == ST_WR_HOLD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            last_mem_q  <= 1'b0;
            sram_addr_q <= '0;
            sram_dout_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            data_oe_q   <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_mem_q  <= last_mem_d;
            sram_addr_q <= sram_addr_d;
            sram_dout_q <= sram_dout_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            ce_n_q      <= ce_n_d;
            oe_n_q      <= oe_n_d;
            we_n_q      <= we_n_d;
            data_oe_q   <= data_oe_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
        end
    end

    assign if_done      = if_done_q;
    assign if_rdata     = if_rdata_q;
    assign if_stall     = if_req & ~if_done_q;
    assign mem_done     = mem_done_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_stall    = mem_req & ~mem_done_q;
    assign sram_addr    = sram_addr_q;
    assign sram_dout    = sram_dout_q;
    assign sram_data_oe = data_oe_q;
    assign sram_ce_n    = ce_n_q;
    assign sram_oe_n    = oe_n_q;
    assign sram_we_n    = we_n_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int RD1 = 2;
    localparam int WR1 = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // DUT0: RD_CYC=1, WR_PULSE_CYC=1, driven from the vector table
    logic        if_req0 = 0, mem_req0 = 0, mem_we0 = 0;
    logic [15:0] if_addr0 = 0, mem_addr0 = 0, mem_wdata0 = 0, sram_din0 = 0;
    logic        if_done0, if_stall0, mem_done0, mem_stall0;
    logic [15:0] if_rdata0, mem_rdata0, sram_dout0;
    logic [17:0] sram_addr0;
    logic        doe0, ce_n0, oe_n0, we_n0;

    // DUT1: RD_CYC=2, WR_PULSE_CYC=3, attached to a small SRAM model
    logic        if_req1 = 0, mem_req1 = 0, mem_we1 = 0;
    logic [15:0] if_addr1 = 0, mem_addr1 = 0, mem_wdata1 = 0, sram_din1;
    logic        if_done1, if_stall1, mem_done1, mem_stall1;
    logic [15:0] if_rdata1, mem_rdata1, sram_dout1;
    logic [17:0] sram_addr1;
    logic        doe1, ce_n1, oe_n1, we_n1;

    mem_port_arbiter #(.RD_CYC(1), .WR_PULSE_CYC(1)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(if_req0), .if_addr(if_addr0), .if_done(if_done0),
        .if_rdata(if_rdata0), .if_stall(if_stall0),
        .mem_req(mem_req0), .mem_we(mem_we0), .mem_addr(mem_addr0),
        .mem_wdata(mem_wdata0), .mem_done(mem_done0), .mem_rdata(mem_rdata0),
        .mem_stall(mem_stall0), .sram_addr(sram_addr0), .sram_dout(sram_dout0),
        .sram_din(sram_din0), .sram_data_oe(doe0), .sram_ce_n(ce_n0),
        .sram_oe_n(oe_n0), .sram_we_n(we_n0)
    );

    mem_port_arbiter #(.RD_CYC(RD1), .WR_PULSE_CYC(WR1)) u_dut1 (
        .clk(clk), .rst(rst),
        .if_req(if_req1), .if_addr(if_addr1), .if_done(if_done1),
        .if_rdata(if_rdata1), .if_stall(if_stall1),
        .mem_req(mem_req1), .mem_we(mem_we1), .mem_addr(mem_addr1),
        .mem_wdata(mem_wdata1), .mem_done(mem_done1), .mem_rdata(mem_rdata1),
        .mem_stall(mem_stall1), .sram_addr(sram_addr1), .sram_dout(sram_dout1),
        .sram_din(sram_din1), .sram_data_oe(doe1), .sram_ce_n(ce_n1),
        .sram_oe_n(oe_n1), .sram_we_n(we_n1)
    );

    // 16-word SRAM model for DUT1 (low address bits only)
    logic [15:0] sram1 [16];
    logic        fill = 1'b0;
    logic [15:0] fill_seed = 16'h0;
    assign sram_din1 = sram1[sram_addr1[3:0]];
    always @(posedge clk) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) sram1[i] <= fill_seed + 16'(i * 16'h1111);
        end else if (!we_n1 && !ce_n1) begin
            sram1[sram_addr1[3:0]] <= sram_dout1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    typedef struct packed {
        logic        if_req;
        logic [15:0] if_addr;
        logic        mem_req;
        logic        mem_we;
        logic [15:0] mem_addr;
        logic [15:0] mem_wdata;
        logic [15:0] din;
        logic        ce_n, oe_n, we_n, doe, if_done, mem_done, if_stall, mem_stall;
        logic [17:0] addr;
        logic [15:0] ifr, memr, dout;
    } vec_t;

    vec_t tbl [17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int we_cnt, first_we, last_we, done_cyc, bad_oe, oe_cnt;
        logic hit;
        // random-phase model state
        logic [15:0] ref_mem [16];
        logic        if_act, mem_act, mem_w, if_seen, mem_seen;
        logic [15:0] if_a, mem_a, mem_d;
        logic        tx_busy, tx_mem, tx_we, lm;
        logic [15:0] tx_addr, tx_exp;
        int          tx_done;
        logic        e_ifd, e_memd;

        //           ifq  ifa       mq   mwe  ma        mwd       din        ce   oe   we   doe  ifd  md   ifs  ms   addr      ifr       memr      dout
        tbl[0]  = '{1'b1,16'h0010,1'b0,1'b0,16'h0000,16'h0000,16'h1234, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,18'h00000,16'h0000,16'h0000,16'h0000};
        tbl[1]  = '{1'b1,16'h0010,1'b0,1'b0,16'h0000,16'h0000,16'h1234, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b0,18'h00010,16'h0000,16'h0000,16'h0000};
        tbl[2]  = '{1'b1,16'h0010,1'b0,1'b0,16'h0000,16'h0000,16'h1234, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,18'h00010,16'h1234,16'h0000,16'h0000};
        tbl[3]  = '{1'b1,16'h0020,1'b1,1'b0,16'h0030,16'h0000,16'h5555, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,18'h00010,16'h1234,16'h0000,16'h0000};
        tbl[4]  = '{1'b1,16'h0020,1'b1,1'b0,16'h0030,16'h0000,16'h5555, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,18'h00030,16'h1234,16'h0000,16'h0000};
        tbl[5]  = '{1'b1,16'h0020,1'b1,1'b0,16'h0030,16'h0000,16'h5555, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,18'h00030,16'h1234,16'h5555,16'h0000};
        tbl[6]  = '{1'b1,16'h0020,1'b1,1'b0,16'h0040,16'h0000,16'hAAAA, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,18'h00030,16'h1234,16'h5555,16'h0000};
        tbl[7]  = '{1'b1,16'h0020,1'b1,1'b0,16'h0040,16'h0000,16'hAAAA, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,1'b1,18'h00020,16'h1234,16'h5555,16'h0000};
        tbl[8]  = '{1'b1,16'h0020,1'b1,1'b0,16'h0040,16'h0000,16'hAAAA, 1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,1'b1,18'h00020,16'hAAAA,16'h5555,16'h0000};
        tbl[9]  = '{1'b0,16'h0000,1'b1,1'b0,16'h0040,16'h0000,16'h0F0F, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,18'h00020,16'hAAAA,16'h5555,16'h0000};
        tbl[10] = '{1'b0,16'h0000,1'b1,1'b0,16'h0040,16'h0000,16'h0F0F, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,18'h00040,16'hAAAA,16'h5555,16'h0000};
        tbl[11] = '{1'b0,16'h0000,1'b1,1'b0,16'h0040,16'h0000,16'h0F0F, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,18'h00040,16'hAAAA,16'h0F0F,16'h0000};
        tbl[12] = '{1'b0,16'h0000,1'b1,1'b1,16'h8000,16'hBEEF,16'h0000, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,18'h00040,16'hAAAA,16'h0F0F,16'h0000};
        tbl[13] = '{1'b0,16'h0000,1'b1,1'b1,16'h8000,16'hBEEF,16'h0000, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b1,18'h08000,16'hAAAA,16'h0F0F,16'hBEEF};
        tbl[14] = '{1'b0,16'h0000,1'b1,1'b1,16'h8000,16'hBEEF,16'h0000, 1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,18'h08000,16'hAAAA,16'h0F0F,16'hBEEF};
        tbl[15] = '{1'b0,16'h0000,1'b1,1'b1,16'h8000,16'hBEEF,16'h0000, 1'b0,1'b1,1'b1,1'b1,1'b0,1'b1,1'b0,1'b0,18'h08000,16'hAAAA,16'h0F0F,16'hBEEF};
        tbl[16] = '{1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'h0000, 1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,18'h08000,16'hAAAA,16'h0F0F,16'h0000};

        // ---- reset state ----
        fill_seed = 16'($urandom);
        fill = 1'b1;
        repeat (2) @(posedge clk);
        #1 fill = 1'b0;
        @(negedge clk);
        chk("rst.ce_n0", ce_n0, 1);
        chk("rst.oe_n0", oe_n0, 1);
        chk("rst.we_n0", we_n0, 1);
        chk("rst.doe0", doe0, 0);
        chk("rst.addr0", sram_addr0, 0);
        chk("rst.dout0", sram_dout0, 0);
        chk("rst.ifr0", if_rdata0, 0);
        chk("rst.memr0", mem_rdata0, 0);
        chk("rst.done0", {if_done0, mem_done0}, 0);
        chk("rst.strobes1", {ce_n1, oe_n1, we_n1, doe1}, 4'b1110);
        @(posedge clk); #1;
        rst = 1'b1;

        // ---- table-driven sequence on DUT0 ----
        for (int i = 0; i < 17; i++) begin
            if_req0 = tbl[i].if_req;   if_addr0 = tbl[i].if_addr;
            mem_req0 = tbl[i].mem_req; mem_we0 = tbl[i].mem_we;
            mem_addr0 = tbl[i].mem_addr; mem_wdata0 = tbl[i].mem_wdata;
            sram_din0 = tbl[i].din;
            @(negedge clk);
            chk($sformatf("v%0d.ce_n", i), ce_n0, tbl[i].ce_n);
            chk($sformatf("v%0d.oe_n", i), oe_n0, tbl[i].oe_n);
            chk($sformatf("v%0d.we_n", i), we_n0, tbl[i].we_n);
            chk($sformatf("v%0d.data_oe", i), doe0, tbl[i].doe);
            chk($sformatf("v%0d.if_done", i), if_done0, tbl[i].if_done);
            chk($sformatf("v%0d.mem_done", i), mem_done0, tbl[i].mem_done);
            chk($sformatf("v%0d.if_stall", i), if_stall0, tbl[i].if_stall);
            chk($sformatf("v%0d.mem_stall", i), mem_stall0, tbl[i].mem_stall);
            chk($sformatf("v%0d.sram_addr", i), sram_addr0, tbl[i].addr);
            chk($sformatf("v%0d.if_rdata", i), if_rdata0, tbl[i].ifr);
            chk($sformatf("v%0d.mem_rdata", i), mem_rdata0, tbl[i].memr);
            if (tbl[i].doe) chk($sformatf("v%0d.sram_dout", i), sram_dout0, tbl[i].dout);
            @(posedge clk); #1;
        end

        // ---- DUT1: 3-cycle write pulse ----
        mem_req1 = 1; mem_we1 = 1; mem_addr1 = 16'h0005; mem_wdata1 = 16'hC0DE;
        we_cnt = 0; first_we = -1; last_we = -1; done_cyc = -1; bad_oe = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (!we_n1) begin
                we_cnt++;
                if (first_we < 0) first_we = k;
                last_we = k;
            end
            if (!oe_n1 && doe1) bad_oe++;
            if (mem_done1 && done_cyc < 0) done_cyc = k;
            @(posedge clk); #1;
            if (done_cyc >= 0) mem_req1 = 0;
        end
        chk("wr3.we_cnt", we_cnt, 3);
        chk("wr3.first_we", first_we, 2);
        chk("wr3.last_we", last_we, 4);
        chk("wr3.done_cyc", done_cyc, 5);
        chk("wr3.oe_with_drive", bad_oe, 0);
        chk("wr3.sram_word", sram1[5], 16'hC0DE);

        // ---- DUT1: 2-cycle read of the word just written ----
        mem_req1 = 1; mem_we1 = 0; mem_addr1 = 16'h0005;
        oe_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (!oe_n1) oe_cnt++;
            if (mem_done1 && done_cyc < 0) begin
                done_cyc = k;
                chk("rd2.mem_rdata", mem_rdata1, 16'hC0DE);
                chk("rd2.sram_addr", sram_addr1, 18'h00005);
            end
            @(posedge clk); #1;
            if (done_cyc >= 0) mem_req1 = 0;
        end
        chk("rd2.done_cyc", done_cyc, RD1 + 1);
        chk("rd2.oe_cnt", oe_cnt, RD1);

        // ---- DUT1: reset during WR_PULSE, then re-issued write ----
        mem_req1 = 1; mem_we1 = 1; mem_addr1 = 16'h0006; mem_wdata1 = 16'h7777;
        hit = 0;
        for (int k = 0; k < 10 && !hit; k++) begin
            @(negedge clk);
            if (!we_n1) hit = 1;
            else begin @(posedge clk); #1; end
        end
        chk("rstwr.reached_pulse", hit, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstwr.we_n_async", we_n1, 1);
        chk("rstwr.doe_async", doe1, 0);
        chk("rstwr.ce_n_async", ce_n1, 1);
        done_cyc = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (mem_done1) done_cyc++;
        end
        chk("rstwr.no_done", done_cyc, 0);
        chk("rstwr.word_unwritten", sram1[6] == 16'h7777, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        we_cnt = 0; done_cyc = -1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (!we_n1) we_cnt++;
            if (mem_done1 && done_cyc < 0) done_cyc = k;
            @(posedge clk); #1;
            if (done_cyc >= 0) mem_req1 = 0;
        end
        chk("rstwr.retry_done_cyc", done_cyc, WR1 + 2);
        chk("rstwr.retry_we_cnt", we_cnt, WR1);
        chk("rstwr.retry_word", sram1[6], 16'h7777);

        // ---- DUT1: randomized traffic against a transaction-level model ----
        rst = 1'b0;
        fill_seed = 16'($urandom);
        fill = 1'b1;
        @(posedge clk); #1;
        fill = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 16; i++) ref_mem[i] = fill_seed + 16'(i * 16'h1111);
        if_act = 0; mem_act = 0; mem_w = 0; if_seen = 0; mem_seen = 0;
        if_a = 0; mem_a = 0; mem_d = 0;
        tx_busy = 0; tx_mem = 0; tx_we = 0; lm = 0; tx_addr = 0; tx_exp = 0; tx_done = 0;
        for (int c = 0; c < 700; c++) begin
            if (if_act && if_seen) if_act = 0;
            if (mem_act && mem_seen) mem_act = 0;
            if (!if_act && $urandom_range(0, 2) == 0) begin
                if_act = 1;
                if_a = 16'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) if_a[15] = 1'b1;
            end
            if (!mem_act && $urandom_range(0, 2) == 0) begin
                mem_act = 1;
                mem_w = 1'($urandom_range(0, 1));
                mem_a = 16'($urandom_range(0, 15));
                if ($urandom_range(0, 1) == 1) mem_a[14] = 1'b1;
                mem_d = 16'($urandom);
            end
            if_req1 = if_act; if_addr1 = if_a;
            mem_req1 = mem_act; mem_we1 = mem_w; mem_addr1 = mem_a; mem_wdata1 = mem_d;

            // Arbiter free: grant by priority rule, fix the completion cycle.
            if (!tx_busy && (if_act || mem_act)) begin
                tx_busy = 1;
                tx_mem = mem_act && (!if_act || !lm);
                lm = tx_mem;
                tx_we = tx_mem && mem_w;
                tx_addr = tx_mem ? mem_a : if_a;
                if (tx_we) begin
                    ref_mem[tx_addr[3:0]] = mem_d;
                    tx_done = c + WR1 + 2;
                end else begin
                    tx_exp = ref_mem[tx_addr[3:0]];
                    tx_done = c + RD1 + 1;
                end
            end
            e_ifd  = tx_busy && (c == tx_done) && !tx_mem;
            e_memd = tx_busy && (c == tx_done) && tx_mem;

            @(negedge clk);
            chk("rnd.if_done", if_done1, e_ifd);
            chk("rnd.mem_done", mem_done1, e_memd);
            chk("rnd.if_stall", if_stall1, if_act & ~e_ifd);
            chk("rnd.mem_stall", mem_stall1, mem_act & ~e_memd);
            if (!oe_n1 && doe1) chk("rnd.oe_while_driving", 1, 0);
            if (tx_busy && c == tx_done) begin
                chk("rnd.sram_addr", sram_addr1, {2'b00, tx_addr});
                if (!tx_we) begin
                    if (tx_mem) chk("rnd.mem_rdata", mem_rdata1, tx_exp);
                    else        chk("rnd.if_rdata", if_rdata1, tx_exp);
                end
                tx_busy = 0;
            end
            if_seen = if_done1;
            mem_seen = mem_done1;
            @(posedge clk); #1;
        end
        if_req1 = 0; mem_req1 = 0;
        for (int i = 0; i < 16; i++) chk($sformatf("rnd.final_word%0d", i), sram1[i], ref_mem[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates the single-port off-chip SRAM between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sequences the SRAM strobe timing (CE/OE/WE, data-bus drive) through a small FSM.
- Drives stall outputs that the pipeline control ORs into the PC/IFID write-enable and bubble logic.
- Sits between the IF/MEM stages and the SRAM pin interface.

Parameters:
- ADDR_W, 16: CPU-side address width.
- SRAM_ADDR_W, 18: SRAM address width. CPU address is zero-extended into it.
- DATA_W, 16: data word width.
- RD_CYC, 1: number of cycles OE is held low per read (≥1).
- WR_PULSE_CYC, 1: number of cycles WE is held low per write (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  IF read request, level, held until if_done.
- if_addr  in  ADDR_W  IF read address.
- if_done  out  1  one-cycle pulse; if_rdata valid.
- if_rdata  out  DATA_W  last IF read data, held until next IF completion.
- if_stall  out  1  if_req & ~if_done.
- mem_req  in  1  MEM request, level, held until mem_done.
- mem_we  in  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  in  ADDR_W  MEM address.
- mem_wdata  in  DATA_W  MEM write data.
- mem_done  out  1  one-cycle completion pulse.
- mem_rdata  out  DATA_W  last MEM read data, held.
- mem_stall  out  1  mem_req & ~mem_done.
- sram_addr  out  SRAM_ADDR_W  registered address.
- sram_dout  out  DATA_W  write data to pad.
- sram_din  in  DATA_W  read data from pad.
- sram_data_oe  out  1  pad output enable (drive bus).
- sram_ce_n / sram_oe_n / sram_we_n  out  1 each  active-low strobes.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - ce_n = oe_n = we_n = 1, data_oe = 0.
  - sram_addr, sram_dout, if_rdata, mem_rdata = 0.
  - done pulses = 0.
  - last_mem flag = 0.
- States: IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD. Counter width is clog2(max(RD_CYC, WR_PULSE_CYC)) + 1.
- IDLE: sample requests and grant one.
  - Grant rule: if both request, MEM wins unless last_mem = 1, in which case IF wins. last_mem is set on a MEM grant and cleared on an IF grant.
  - On grant, register the address (zero-extended) and grant owner. For a write, also register wdata.
  - Read grant → RD. Write grant → WR_SETUP.
  - No grant → stay in IDLE, all strobes inactive.
- RD: ce_n = 0, oe_n = 0 for RD_CYC cycles.
  - sram_din is captured into the owner's rdata on the last RD cycle edge.
  - → RD_DONE.
- RD_DONE: strobes inactive; owner's done = 1. → IDLE.
  - Read latency is RD_CYC + 1 cycles from the grant cycle to done.
- WR_SETUP: ce_n = 0, data_oe = 1, we_n = 1. → WR_PULSE.
- WR_PULSE: we_n = 0 for WR_PULSE_CYC cycles; ce_n = 0, data_oe = 1. → WR_HOLD.
- WR_HOLD: we_n = 1, data_oe = 1, ce_n = 0; mem_done = 1. → IDLE.
  - Write latency is WR_PULSE_CYC + 2 cycles.
  - oe_n is never low while data_oe = 1.
- Strobe outputs are registered state decodes and must be glitch-free.
- Requesters must drop or update req on the cycle after done. IDLE re-samples req fresh, so the minimum gap between accesses is one IDLE cycle.
- IF never writes: if_req is always a read.
- Request changes mid-access are ignored; the latched address and data are used.
- Reset mid-access aborts the access. No done is generated; the requester re-issues after reset.
- Stalls are combinational from req and done. A stalled requester sees stall = 1 on every cycle from req assertion up to, but excluding, its done cycle.

Decomposition:
- Shared package cpu_mem_pkg:
  - state enum (IDLE, RD, RD_DONE, WR_SETUP, WR_PULSE, WR_HOLD)
  - owner encoding OWN_IF = 0, OWN_MEM = 1
  - default widths ADDR_W, SRAM_ADDR_W, DATA_W
- One sub-module, mem_arb_timer: a loadable down-counter with a terminal-count flag, used for both RD_CYC and WR_PULSE_CYC.
- Grant logic, FSM and strobe registers stay in the top module.

Test Plan:
- IF read only, RD_CYC = 1: if_req = 1, if_addr = 0x0010 at cycle 0; sram_din = 0x1234.
  → sram_addr = 0x00010 and oe_n = 0 in cycle 1; if_done = 1 and if_rdata = 0x1234 in cycle 2; if_stall = 1 in cycles 0–1 only.
- MEM write, WR_PULSE_CYC = 1: mem_addr = 0x8000, mem_wdata = 0xBEEF.
  → data_oe = 1 in cycles 1–3; we_n = 0 in cycle 2 only; sram_dout = 0xBEEF; mem_done in cycle 3; oe_n = 1 throughout.
- IF and MEM read requested together and held: MEM is granted first (done in cycle 2); IF is granted at the next IDLE.
  - If MEM re-requests together with IF, IF still wins that grant (last_mem = 1).
- WR_PULSE_CYC = 3 write: we_n is low for exactly 3 consecutive cycles; mem_done is 5 cycles after the grant.
- Reset during WR_PULSE: we_n → 1 and data_oe → 0 without waiting for a clock edge; no mem_done.
  - After reset release with mem_req still high, a fresh write completes normally.
- Read-data hold: an IF read returns 0xAAAA, then a MEM read returns 0x5555.
  → if_rdata stays 0xAAAA; mem_rdata = 0x5555.
